// File: rtl/mssd_tx_scheduler.sv
// Four-requester round-robin serial frame scheduler: start bit, 6-bit
// {len,dest} header MSB first, 8*len payload bits pulled from the winner, idle gap.
module mssd_tx_scheduler #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] len,
    input  logic [7:0]  dest,
    input  logic [3:0]  payBit,
    output logic        serOut,
    output logic [3:0]  grant,
    output logic [3:0]  bitTake,
    output logic        done,
    output logic        lenErr,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        HDR   = 3'd2,
        PAY   = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [1:0] rr;
    logic [1:0] win_idx;
    logic [3:0] len_l;
    logic [5:0] hdr_sh;
    logic [2:0] hdr_cnt;
    logic [6:0] pay_cnt;
    logic [3:0] gap_cnt;

    logic [3:0] eligible;
    logic [3:0] zero_len;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    logic [3:0] len_sel;
    logic [1:0] dest_sel;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = req[i] & (|len[4*i +: 4]);
            zero_len[i] = req[i] & ~(|len[4*i +: 4]);
        end
    end

    // Search starts at rr and wraps; the first eligible requester wins.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        cand  = rr;
        for (int k = 0; k < 4; k++) begin
            cand = rr + 2'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign len_sel  = len[{pick, 2'b00} +: 4];
    assign dest_sel = dest[{pick, 1'b0} +: 2];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = START;
            START:   state_n = HDR;
            HDR:     if (hdr_cnt == 3'd5) state_n = PAY;
            PAY:     if (pay_cnt == 7'd1) state_n = GAP;
            GAP:     if (gap_cnt == 4'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        serOut  = 1'b1;
        bitTake = 4'b0000;
        done    = 1'b0;
        case (state)
            START: serOut = 1'b0;
            HDR:   serOut = hdr_sh[5];
            PAY: begin
                serOut  = payBit[win_idx];
                bitTake = grant;
            end
            GAP:   done = (gap_cnt == 4'd1);
            default: ;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 4'b0000;
            lenErr  <= 1'b0;
            rr      <= 2'd0;
            win_idx <= 2'd0;
            len_l   <= 4'd0;
            hdr_sh  <= 6'd0;
            hdr_cnt <= 3'd0;
            pay_cnt <= 7'd0;
            gap_cnt <= 4'd0;
        end else begin
            state  <= state_n;
            lenErr <= lenErr | (|zero_len);
            case (state)
                IDLE: begin
                    // Everything the frame needs is captured here, so later
                    // changes on req/len/dest cannot disturb it.
                    if (found) begin
                        grant   <= 4'b0001 << pick;
                        win_idx <= pick;
                        len_l   <= len_sel;
                        hdr_sh  <= {len_sel, dest_sel};
                        hdr_cnt <= 3'd0;
                    end
                end
                HDR: begin
                    hdr_sh  <= hdr_sh << 1;
                    hdr_cnt <= hdr_cnt + 3'd1;
                    if (hdr_cnt == 3'd5) pay_cnt <= {len_l, 3'b000};
                end
                PAY: begin
                    pay_cnt <= pay_cnt - 7'd1;
                    if (pay_cnt == 7'd1) gap_cnt <= 4'(GAP_CYCLES);
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        grant <= 4'b0000;
                        rr    <= win_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mssd_tx_scheduler.sv
// Bench for mssd_tx_scheduler: frames are queued as expected serial bit
// streams and compared cycle by cycle against serOut/grant/bitTake/done.
module tb_mssd_tx_scheduler;

    localparam int G = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [7:0]  dest;
    logic [3:0]  payBit;
    logic        serOut;
    logic [3:0]  grant;
    logic [3:0]  bitTake;
    logic        done;
    logic        lenErr;
    logic [2:0]  state_dbg;

    mssd_tx_scheduler #(.GAP_CYCLES(G)) dut (
        .clock(clock), .reset(reset), .req(req), .len(len), .dest(dest),
        .payBit(payBit), .serOut(serOut), .grant(grant), .bitTake(bitTake),
        .done(done), .lenErr(lenErr), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [127:0] pay_data [4];
    int           ptr  [4] = '{default: 0};
    int           mptr [4] = '{default: 0};
    bit           ptr_clr = 1'b0;

    logic exp_q [$];
    int   win_q [$];
    int   len_q [$];

    // Requester model: each requester advances its bit pointer when taken.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ptr_clr) ptr[i] <= 0;
            else if (bitTake[i]) ptr[i] <= ptr[i] + 1;
        end
    end

    always @* begin
        for (int i = 0; i < 4; i++) payBit[i] = pay_data[i][127 - (ptr[i] % 128)];
    end

    task automatic clear_ptrs();
        ptr_clr = 1'b1;
        @(posedge clock);
        #1 ptr_clr = 1'b0;
        for (int i = 0; i < 4; i++) mptr[i] = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        win_q.delete();
        len_q.delete();
        clear_ptrs();
    endtask

    task automatic push_frame(input int i, input int l, input int d);
        logic [5:0] h;
        h = {l[3:0], d[1:0]};
        exp_q.push_back(1'b0);
        for (int b = 5; b >= 0; b--) exp_q.push_back(h[b]);
        for (int k = 0; k < 8 * l; k++) exp_q.push_back(pay_data[i][127 - mptr[i] - k]);
        mptr[i] = mptr[i] + 8 * l;
        for (int k = 0; k < G; k++) exp_q.push_back(1'b1);
        win_q.push_back(i);
        len_q.push_back(l);
    endtask

    // Waits for the START cycle, then checks the whole frame and the IDLE after it.
    task automatic check_frame(input bit drop, input bit mutate, input bit b2b);
        int w, l, n, waited;
        logic e;
        logic [3:0] oh, exp_take;
        if (win_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_queue: got empty queue, required a queued frame");
            return;
        end
        w = win_q.pop_front();
        l = len_q.pop_front();
        n = 7 + 8 * l + G;
        oh = 4'b0001 << w;
        waited = 0;
        @(negedge clock);
        while (grant === 4'b0000 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        if (grant === 4'b0000) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no grant in %0d cycles, required %b", waited, oh);
            exp_q.delete();
            return;
        end
        if (b2b) begin
            checks++;
            if (waited !== 0) begin
                errors++;
                $display("FAIL frame_spacing: got %0d extra idle cycles, required 0", waited);
            end
        end
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clock);
            e = exp_q.pop_front();
            exp_take = (c >= 7 && c < 7 + 8 * l) ? oh : 4'b0000;
            checks++;
            if (serOut !== e) begin
                errors++;
                $display("FAIL serout cyc=%0d: got %b, required %b", c, serOut, e);
            end
            checks++;
            if (grant !== oh) begin
                errors++;
                $display("FAIL grant cyc=%0d: got %b, required %b", c, grant, oh);
            end
            checks++;
            if (bitTake !== exp_take) begin
                errors++;
                $display("FAIL bittake cyc=%0d: got %b, required %b", c, bitTake, exp_take);
            end
            checks++;
            if (done !== (c == n - 1)) begin
                errors++;
                $display("FAIL done cyc=%0d: got %b, required %b", c, done, (c == n - 1));
            end
            if (c == 0 && drop) req = 4'b0000;
            if (c == 1 && mutate) begin
                req  = 4'b0000;
                len  = 16'h5555;
                dest = ~dest;
            end
        end
        @(negedge clock);
        checks++;
        if (grant !== 4'b0000 || serOut !== 1'b1 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL frame_end: got grant=%b ser=%b st=%0d, required 0000/1/0",
                     grant, serOut, state_dbg);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0101;
        len   = 16'h0000;
        dest  = 8'h00;
        repeat (3) @(negedge clock);
        checks++;
        if (serOut !== 1'b1 || grant !== 4'b0000 || bitTake !== 4'b0000 ||
            done !== 1'b0 || lenErr !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got ser=%b grant=%b take=%b done=%b err=%b st=%0d, required 1/0000/0000/0/0/0",
                     serOut, grant, bitTake, done, lenErr, state_dbg);
        end
        req = 4'b0000;
        reset = 1'b0;
        clear_ptrs();
    endtask

    task automatic test_single_frame();
        pay_data[0] = {8'hA5, 8'h3C, 112'h0};
        @(negedge clock);
        len  = 16'h0002;
        dest = 8'h03;
        req  = 4'b0001;
        push_frame(0, 2, 3);
        check_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < 4; i++) pay_data[i] = {$urandom, $urandom, $urandom, $urandom};
        dest = 8'($urandom_range(0, 255));
        len  = 16'h1111;
        for (int f = 0; f < 5; f++) push_frame(order[f], 1, int'(dest[2 * order[f] +: 2]));
        @(negedge clock);
        req = 4'b1111;
        for (int f = 0; f < 5; f++) check_frame(f == 4, 1'b0, f > 0);
    endtask

    task automatic test_zero_len();
        apply_reset();
        pay_data[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        len  = 16'h0001;
        dest = 8'($urandom_range(0, 255));
        req  = 4'b0101;
        push_frame(0, 1, int'(dest[1:0]));
        check_frame(1'b1, 1'b0, 1'b0);
        checks++;
        if (lenErr !== 1'b1) begin
            errors++;
            $display("FAIL lenerr_set: got %b, required 1", lenErr);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (lenErr !== 1'b1 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL lenerr_sticky: got err=%b grant=%b, required 1/0000", lenErr, grant);
        end
    endtask

    task automatic test_max_len();
        apply_reset();
        pay_data[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        len  = 16'h000F;
        dest = 8'h02;
        req  = 4'b0001;
        push_frame(0, 15, 2);
        check_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_pay();
        apply_reset();
        for (int i = 0; i < 4; i++) pay_data[i] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        len  = 16'h2110;
        dest = 8'($urandom_range(0, 255));
        req  = 4'b0100;
        push_frame(2, 1, int'(dest[5:4]));
        check_frame(1'b1, 1'b0, 1'b0);
        req = 4'b1000;
        @(negedge clock);
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL rr_after_frame: got %b, required 1000", grant);
        end
        repeat (11) @(negedge clock);
        checks++;
        if (bitTake !== 4'b1000) begin
            errors++;
            $display("FAIL pay_cycle5: got take=%b, required 1000", bitTake);
        end
        reset = 1'b1;
        req   = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (serOut !== 1'b1 || grant !== 4'b0000 || bitTake !== 4'b0000 ||
                done !== 1'b0 || state_dbg !== 3'd0) begin
                errors++;
                $display("FAIL reset_mid_pay cyc=%0d: got ser=%b grant=%b take=%b done=%b st=%0d, required 1/0000/0000/0/0",
                         c, serOut, grant, bitTake, done, state_dbg);
            end
        end
        push_frame(1, 1, int'(dest[3:2]));
        reset = 1'b0;
        check_frame(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_mid_change();
        apply_reset();
        pay_data[0] = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        len  = 16'h0003;
        dest = 8'h01;
        req  = 4'b0001;
        push_frame(0, 3, 1);
        check_frame(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_zero_len();
        test_max_len();
        test_reset_mid_pay();
        test_mid_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mssd_tx_scheduler.md
MSSD_TX_SCHEDULER -- requirements
Module: mssd_tx_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 1: idle-high cycles inserted after each frame; legal values 1..15.
REQ-002 The block SHALL have port clock, input, 1 bit: sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i]=1 means requester i has a frame pending.
REQ-005 The block SHALL have port len, input, 16 bits: len[4i+3:4i] is the payload length in bytes for requester i.
REQ-006 The block SHALL have port dest, input, 8 bits: dest[2i+1:2i] is the 2-bit destination port for requester i.
REQ-007 The block SHALL have port payBit, input, 4 bits: payBit[i] is the current payload bit of requester i.
REQ-008 The block SHALL have port serOut, output, 1 bit: serial line; idle level 1.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot winner for the frame in progress; 0 when no frame is in progress.
REQ-010 The block SHALL have port bitTake, output, 4 bits: bitTake[i]=1 means payBit[i] is sampled this cycle; requester i advances to its next bit on that edge.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a frame.
REQ-012 The block SHALL have port lenErr, output, 1 bit: sticky flag, set when a requester asserts req with len=0.

Function
REQ-013 The frame format SHALL be: 1 start bit (0); 6 header bits MSB first {L[3:0], D[1:0]}; then 8*L payload bits.
REQ-014 The FSM SHALL have states IDLE, START, HDR, PAY and GAP.
REQ-015 IDLE: serOut=1. If any eligible req (req[i]=1 and len nonzero) is present, pick a round-robin winner; latch its L and D; set grant; go to START on the next edge.
REQ-016 Round-robin order SHALL start the search at pointer rr: rr, rr+1, ... mod 4. After a frame completes, rr SHALL become winner+1 mod 4.
REQ-017 START SHALL last 1 cycle with serOut=0, then go to HDR.
REQ-018 HDR SHALL last 6 cycles, driving serOut = L[3], L[2], L[1], L[0], D[1], D[0] in that order, then go to PAY.
REQ-019 PAY SHALL last exactly 8*L cycles, with serOut = payBit[winner] combinationally and bitTake = grant; bitTake SHALL be 0 in all other states.
REQ-020 The payload counter SHALL be 7 bits, loaded with 8*L (L<<3, max 120) and decremented each PAY cycle; PAY exits when it reaches 1.
REQ-021 GAP SHALL last GAP_CYCLES cycles with serOut=1 and grant still held. done SHALL pulse in the last GAP cycle. grant SHALL clear and the FSM SHALL return to IDLE on the next edge.
REQ-022 Total frame occupancy SHALL be 7 + 8*L + GAP_CYCLES cycles from the START cycle to the return to IDLE.
REQ-023 Changes to req, len or dest after the IDLE decision SHALL NOT affect the frame in progress.
REQ-024 Deassertion of req[winner] mid-frame SHALL NOT abort the frame; the full frame SHALL be transmitted.
REQ-025 A requester with req=1 and len=0 SHALL be skipped by arbitration, and lenErr SHALL be set on the next edge; it SHALL stay set until reset.
REQ-026 A new arbitration SHALL occur only in IDLE; back-to-back frames SHALL therefore be separated by GAP_CYCLES+1 idle-high cycles minimum.
REQ-027 serOut SHALL be glitch-free per cycle: it is a function of registered state, except payBit passthrough in PAY.

Reset
REQ-028 On reset=1 at a rising edge: state SHALL become IDLE, serOut=1, grant=0, bitTake=0, done=0, lenErr=0, rr=0, and the counters SHALL become 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame immediately at the next edge; no done pulse SHALL be produced.
REQ-030 While reset is high, no arbitration SHALL occur.

Verification
REQ-031 Single frame: req=0001, len[3:0]=2, dest[1:0]=3, payload 0xA5,0x3C -> serOut = 0, 001011, 16 payload bits; bitTake[0] high 16 cycles; done pulses at cycle 7+16+1 after START.
REQ-032 Round-robin: req=1111 held, all len=1 -> grants in order 0001, 0010, 0100, 1000, 0001; each frame occupies 16 cycles.
REQ-033 Zero length: req=0100 with len[11:8]=0, req=0001 with len=1 -> only requester 0 is granted; lenErr=1 and stays 1.
REQ-034 Maximum length: len=15 -> PAY lasts exactly 120 cycles; the counter does not wrap; header is 1111DD.
REQ-035 Reset mid-PAY: assert reset in payload cycle 5 -> next cycle serOut=1, grant=0, no done pulse; a following req=0010 is granted first because rr=0 search finds it.
REQ-036 Mid-frame changes: toggle req[winner] low and change len during HDR -> header and payload length are unchanged and the frame completes normally.
